// File: rtl/tcb_pkg.sv
// Shared TCB types: split-adapter FSM states and the response-pipeline tag.
package tcb_pkg;

    // Tag fields are sized for the widest bus the library supports (up to 256 byte lanes).
    localparam int TCB_OFF_MAX = 8;
    localparam int TCB_SIZ_MAX = 4;

    typedef enum logic {
        TCB_SPLIT_IDLE,
        TCB_SPLIT_SECOND
    } tcb_split_state_t;

    typedef struct packed {
        logic                   vld;
        logic                   lst;
        logic [TCB_OFF_MAX-1:0] off;
        logic [TCB_SIZ_MAX-1:0] siz;
        logic                   wen;
    } tcb_split_tag_t;

    localparam int TCB_TAG_W = $bits(tcb_split_tag_t);

endpackage

// File: rtl/tcb_lib_rsp_pipe.sv
// DLY-deep shift register carrying one tag per accepted subordinate beat.
module tcb_lib_rsp_pipe
    import tcb_pkg::*;
#(
    parameter int DLY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TCB_TAG_W-1:0] req_tag,
    output logic [TCB_TAG_W-1:0] rsp_tag
);

    logic [TCB_TAG_W-1:0] stage [DLY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= req_tag;
            for (int i = 1; i < DLY; i++) stage[i] <= stage[i-1];
        end
    end

    assign rsp_tag = stage[DLY-1];

endmodule

// File: rtl/tcb_lib_misalign_split.sv
// Converts unaligned LSB-aligned manager transfers into aligned byte-enabled beats,
// splitting word-crossing transfers in two and merging their read data.
module tcb_lib_misalign_split
    import tcb_pkg::*;
#(
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int SLW = 8,
    parameter int DLY = 1,
    localparam int BEN = DBW / SLW,
    localparam int OFF = $clog2(BEN),
    localparam int SZW = $clog2(OFF + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           man_vld,
    output logic           man_rdy,
    input  logic           man_wen,
    input  logic [ABW-1:0] man_adr,
    input  logic [SZW-1:0] man_siz,
    input  logic [DBW-1:0] man_wdt,
    output logic [DBW-1:0] man_rdt,
    output logic           man_err,
    output logic           sub_vld,
    input  logic           sub_rdy,
    output logic           sub_wen,
    output logic [ABW-1:0] sub_adr,
    output logic [BEN-1:0] sub_byt,
    output logic [DBW-1:0] sub_wdt,
    input  logic [DBW-1:0] sub_rdt,
    input  logic           sub_err
);

    localparam int LW2 = 2 * BEN;

    function automatic logic [DBW-1:0] rot_left(input logic [DBW-1:0] d, input logic [OFF-1:0] o);
        logic [DBW-1:0] r;
        r = '0;
        for (int i = 0; i < BEN; i++) r[((i + int'(o)) % BEN)*SLW +: SLW] = d[i*SLW +: SLW];
        return r;
    endfunction

    function automatic logic [DBW-1:0] rot_right(input logic [DBW-1:0] d, input logic [OFF-1:0] o);
        logic [DBW-1:0] r;
        r = '0;
        for (int i = 0; i < BEN; i++) r[i*SLW +: SLW] = d[((i + int'(o)) % BEN)*SLW +: SLW];
        return r;
    endfunction

    function automatic logic [DBW-1:0] lane_mask(input int k);
        logic [DBW-1:0] r;
        r = '0;
        for (int i = 0; i < BEN; i++) r[i*SLW +: SLW] = (i < k) ? {SLW{1'b1}} : {SLW{1'b0}};
        return r;
    endfunction

    function automatic logic [DBW-1:0] byte_expand(input logic [BEN-1:0] b);
        logic [DBW-1:0] r;
        for (int i = 0; i < BEN; i++) r[i*SLW +: SLW] = {SLW{b[i]}};
        return r;
    endfunction

    // A beat transfers on the cycle where sub_vld && sub_rdy; the manager side transfers on
    // man_vld && man_rdy, which only happens together with the last subordinate beat.
    tcb_split_state_t state;

    logic [OFF-1:0] off;
    logic [OFF:0]   n;
    logic [OFF+1:0] end_pos;
    logic           crossing;
    logic [LW2-1:0] lane_sel;
    logic [ABW-1:0] word_adr;
    logic           tag_lst;

    assign off      = man_adr[OFF-1:0];
    assign n        = (OFF+1)'(1) << man_siz;
    assign end_pos  = {2'b00, off} + {1'b0, n};
    assign crossing = end_pos > (OFF+2)'(BEN);
    // Low half holds the first-word lanes, high half spills into the next word.
    assign lane_sel = ((LW2'(1) << n) - LW2'(1)) << off;
    assign word_adr = {man_adr[ABW-1:OFF], {OFF{1'b0}}};

    always_comb begin
        sub_vld = 1'b0;
        man_rdy = 1'b0;
        sub_adr = word_adr;
        sub_byt = lane_sel[BEN-1:0];
        tag_lst = 1'b1;
        if (rst_n) begin
            case (state)
                TCB_SPLIT_IDLE: begin
                    sub_vld = man_vld;
                    man_rdy = sub_rdy & ~crossing;
                    tag_lst = ~crossing;
                end
                TCB_SPLIT_SECOND: begin
                    sub_vld = 1'b1;
                    man_rdy = sub_rdy;
                    sub_adr = word_adr + ABW'(BEN);
                    sub_byt = lane_sel[LW2-1:BEN];
                end
                default: ;
            endcase
        end
    end

    assign sub_wen = man_wen;
    assign sub_wdt = rot_left(man_wdt, off) & byte_expand(sub_byt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TCB_SPLIT_IDLE;
        end else begin
            case (state)
                TCB_SPLIT_IDLE:   if (man_vld && sub_rdy && crossing) state <= TCB_SPLIT_SECOND;
                TCB_SPLIT_SECOND: if (sub_rdy) state <= TCB_SPLIT_IDLE;
                default:          state <= TCB_SPLIT_IDLE;
            endcase
        end
    end

    tcb_split_tag_t req_tag;
    tcb_split_tag_t rsp_tag;

    always_comb begin
        req_tag     = '0;
        req_tag.vld = sub_vld & sub_rdy;
        req_tag.lst = tag_lst;
        req_tag.off = TCB_OFF_MAX'(off);
        req_tag.siz = TCB_SIZ_MAX'(man_siz);
        req_tag.wen = man_wen;
    end

    tcb_lib_rsp_pipe #(.DLY(DLY)) u_rsp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_tag (req_tag),
        .rsp_tag (rsp_tag)
    );

    logic [OFF-1:0] toff;
    logic [OFF:0]   tn;
    logic [OFF+1:0] tend;
    logic           tcross;
    logic [DBW-1:0] rdt_rot;
    logic [DBW-1:0] head_mask;
    logic [DBW-1:0] merge_q;
    logic           err_q;
    logic           unused_tag_bits;

    assign toff      = rsp_tag.off[OFF-1:0];
    assign tn        = (OFF+1)'(1) << rsp_tag.siz[SZW-1:0];
    assign tend      = {2'b00, toff} + {1'b0, tn};
    assign tcross    = tend > (OFF+2)'(BEN);
    assign rdt_rot   = rot_right(sub_rdt, toff);
    assign head_mask = lane_mask(BEN - int'(toff));
    assign unused_tag_bits = ^{rsp_tag.off, rsp_tag.siz};

    always_comb begin
        man_rdt = '0;
        man_err = 1'b0;
        if (rsp_tag.vld && rsp_tag.lst) begin
            man_err = sub_err | (tcross & err_q);
            if (!rsp_tag.wen) begin
                man_rdt = (tcross ? ((merge_q & head_mask) | (rdt_rot & ~head_mask)) : rdt_rot)
                          & lane_mask(int'(tn));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            merge_q <= '0;
            err_q   <= 1'b0;
        end else if (rsp_tag.vld) begin
            if (!rsp_tag.lst) begin
                merge_q <= rdt_rot;
                err_q   <= sub_err;
            end else if (tcross) begin
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tcb_lib_misalign_split.sv
// Bench for tcb_lib_misalign_split: byte-level memory reference model, subordinate memory, directed + random transfers.
module tb_tcb_lib_misalign_split;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        man_vld, man_rdy, man_wen, man_err;
  logic [31:0] man_adr, man_wdt, man_rdt;
  logic [1:0]  man_siz;
  logic        sub_vld, sub_rdy, sub_wen, sub_err;
  logic [31:0] sub_adr, sub_wdt, sub_rdt;
  logic [3:0]  sub_byt;

  tcb_lib_misalign_split dut (
    .clk(clk), .rst_n(rst_n),
    .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen), .man_adr(man_adr),
    .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(man_rdt), .man_err(man_err),
    .sub_vld(sub_vld), .sub_rdy(sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
    .sub_byt(sub_byt), .sub_wdt(sub_wdt), .sub_rdt(sub_rdt), .sub_err(sub_err)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] sub_mem [8];
  logic [7:0]  ref_mem [32];

  // scoreboard
  logic [31:0] beat_adr_q[$];
  logic [3:0]  beat_byt_q[$];
  logic        beat_wen_q[$];
  logic [31:0] beat_wdt_q[$];
  logic        beat_err_q[$];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  logic        rsp_pend, rsp_err, due, prev_stalled, man_hs, rnd_rdy;
  logic [31:0] rsp_word, prev_adr, prev_wdt, last_rdt;
  logic [3:0]  prev_byt;
  logic        last_err;
  int          beats_done, nbeats, stall_left;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // one clock cycle: drive at negedge, sample #1 later, return #1 after posedge
  task automatic step();
    logic [31:0] b_adr, b_wdt, bmask;
    logic [3:0]  b_byt;
    logic        b_wen, b_err;
    logic [2:0]  idx;
    @(negedge clk);
    if (rsp_pend) begin
      sub_rdt = rsp_word;
      sub_err = rsp_err;
    end else begin
      sub_rdt = $urandom;
      sub_err = 1'($urandom_range(0, 1));
    end
    rsp_pend = 1'b0;
    if (stall_left > 0 && beats_done == 1) begin
      sub_rdy = 1'b0;
      stall_left--;
    end else if (rnd_rdy) begin
      sub_rdy = ($urandom_range(0, 3) != 0);
    end else begin
      sub_rdy = 1'b1;
    end
    #1;
    if (due) begin
      due = 1'b0;
      check("man_rdt", man_rdt, exp_q.pop_front());
      check("man_err", 32'(man_err), 32'(exp_err_q.pop_front()));
      last_rdt = man_rdt;
      last_err = man_err;
    end
    if (prev_stalled) begin
      check("sub_vld_hold", 32'(sub_vld), 32'd1);
      check("sub_adr_hold", sub_adr, prev_adr);
      check("sub_byt_hold", 32'(sub_byt), 32'(prev_byt));
      check("sub_wdt_hold", sub_wdt, prev_wdt);
    end
    prev_stalled = sub_vld && !sub_rdy;
    prev_adr = sub_adr;
    prev_byt = sub_byt;
    prev_wdt = sub_wdt;
    if (man_vld && !man_hs) begin
      check("sub_vld", 32'(sub_vld), 32'd1);
      check("man_rdy", 32'(man_rdy), 32'(sub_vld && sub_rdy && (beats_done + 1 == nbeats)));
    end
    if (sub_vld && sub_rdy) begin
      b_err = 1'b0;
      if (beat_adr_q.size() == 0) begin
        check("beat_extra", 32'(beat_adr_q.size()), 32'd1);
      end else begin
        b_adr = beat_adr_q.pop_front();
        b_byt = beat_byt_q.pop_front();
        b_wen = beat_wen_q.pop_front();
        b_wdt = beat_wdt_q.pop_front();
        b_err = beat_err_q.pop_front();
        for (int l = 0; l < 4; l++) bmask[l*8 +: 8] = {8{b_byt[l]}};
        check("sub_adr", sub_adr, b_adr);
        check("sub_byt", 32'(sub_byt), 32'(b_byt));
        check("sub_wen", 32'(sub_wen), 32'(b_wen));
        if (b_wen) check("sub_wdt", sub_wdt & bmask, b_wdt);
      end
      idx = sub_adr[4:2];
      if (sub_wen) begin
        for (int l = 0; l < 4; l++) if (sub_byt[l]) sub_mem[idx][l*8 +: 8] = sub_wdt[l*8 +: 8];
        rsp_word = $urandom;
      end else begin
        rsp_word = sub_mem[idx];
      end
      rsp_err = b_err;
      rsp_pend = 1'b1;
      beats_done++;
    end
    if (man_vld && man_rdy && !man_hs) begin
      man_hs = 1'b1;
      due = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    man_vld = 1'b0;
    repeat (k) step();
  endtask

  // driver + reference: expectations computed byte by byte from a flat memory
  task automatic xfer(input logic wen, input logic [31:0] adr, input int siz, input logic [31:0] wdt,
                      input logic e0, input logic e1, input int stall2);
    int n, nb, b, lane;
    logic [3:0]  byt [2];
    logic [31:0] wd [2];
    logic [31:0] er, a;
    n = 1 << siz;
    byt[0] = '0; byt[1] = '0; wd[0] = '0; wd[1] = '0; er = '0;
    for (int k = 0; k < n; k++) begin
      a = adr + 32'(k);
      b = (a[31:2] != adr[31:2]) ? 1 : 0;
      lane = int'(a[1:0]);
      byt[b][lane] = 1'b1;
      wd[b][lane*8 +: 8] = wdt[k*8 +: 8];
      if (wen) ref_mem[a[4:0]] = wdt[k*8 +: 8];
      else     er[k*8 +: 8] = ref_mem[a[4:0]];
    end
    nb = (byt[1] != 4'b0000) ? 2 : 1;
    for (int i = 0; i < nb; i++) begin
      beat_adr_q.push_back({adr[31:2], 2'b00} + 32'(4 * i));
      beat_byt_q.push_back(byt[i]);
      beat_wen_q.push_back(wen);
      beat_wdt_q.push_back(wd[i]);
      beat_err_q.push_back(i == 0 ? e0 : e1);
    end
    exp_q.push_back(wen ? 32'h0 : er);
    exp_err_q.push_back(nb == 2 ? (e0 | e1) : e0);
    man_vld = 1'b1;
    man_wen = wen;
    man_adr = adr;
    man_siz = 2'(siz);
    man_wdt = wdt;
    beats_done = 0;
    nbeats = nb;
    stall_left = stall2;
    man_hs = 1'b0;
    for (int c = 0; c < 50 && !man_hs; c++) step();
    check("xfer_done", 32'(man_hs), 32'd1);
    man_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    man_vld = 1'b0; man_wen = 1'b0; man_adr = '0; man_siz = '0; man_wdt = '0;
    sub_rdy = 1'b0; sub_rdt = '0; sub_err = 1'b0;
    rsp_pend = 0; rsp_err = 0; rsp_word = 0; due = 0; prev_stalled = 0; man_hs = 0; rnd_rdy = 0;
    prev_adr = 0; prev_wdt = 0; prev_byt = 0; last_rdt = 0; last_err = 0;
    beats_done = 0; nbeats = 1; stall_left = 0;
    sub_mem[0] = 32'h10203040;
    sub_mem[1] = 32'h50607080;
    for (int w = 2; w < 8; w++) sub_mem[w] = $urandom;
    for (int i = 0; i < 32; i++) ref_mem[i] = sub_mem[i/4][(i%4)*8 +: 8];

    // reset values with a pending manager request
    repeat (2) @(negedge clk);
    man_vld = 1'b1; man_siz = 2'd2; sub_rdy = 1'b1;
    #1;
    check("rst_sub_vld", 32'(sub_vld), 32'd0);
    check("rst_man_rdy", 32'(man_rdy), 32'd0);
    check("rst_man_rdt", man_rdt, 32'd0);
    check("rst_man_err", 32'(man_err), 32'd0);
    man_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed cases
    xfer(1'b0, 32'h0, 2, 32'h0, 1'b0, 1'b0, 0); idle(1);
    check("t1_rdt", last_rdt, 32'h10203040);
    xfer(1'b0, 32'h1, 1, 32'h0, 1'b0, 1'b0, 0); idle(1);
    check("t2_rdt", last_rdt, 32'h00002030);
    xfer(1'b0, 32'h3, 1, 32'h0, 1'b0, 1'b0, 0); idle(1);
    check("t3_rdt", last_rdt, 32'h00008010);
    xfer(1'b1, 32'h6, 2, 32'hAABBCCDD, 1'b0, 1'b0, 0); idle(1);
    xfer(1'b0, 32'h4, 2, 32'h0, 1'b0, 1'b0, 0); idle(1);
    check("t4_readback", last_rdt, 32'hCCDD7080);
    xfer(1'b0, 32'h3, 1, 32'h0, 1'b1, 1'b0, 3); idle(1);
    check("t5_err", 32'(last_err), 32'd1);
    check("t5_rdt", last_rdt, 32'h00008010);

    // reset while the second beat is pending
    @(negedge clk);
    man_vld = 1'b1; man_wen = 1'b0; man_adr = 32'h3; man_siz = 2'd1; sub_rdy = 1'b1;
    #1;
    check("t6_first_byt", 32'(sub_byt), 32'h8);
    @(posedge clk);
    #1;
    check("t6_second_adr", sub_adr, 32'h4);
    check("t6_second_byt", 32'(sub_byt), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_vld", 32'(sub_vld), 32'd0);
    check("t6_rst_rdy", 32'(man_rdy), 32'd0);
    check("t6_rst_rdt", man_rdt, 32'd0);
    check("t6_rst_err", 32'(man_err), 32'd0);
    @(negedge clk);
    man_vld = 1'b0; sub_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    beat_adr_q.delete(); beat_byt_q.delete(); beat_wen_q.delete();
    beat_wdt_q.delete(); beat_err_q.delete(); exp_q.delete(); exp_err_q.delete();
    due = 0; rsp_pend = 0; prev_stalled = 0; man_hs = 1;
    repeat (3) begin
      step();
      check("t6_stale_rdt", man_rdt, 32'd0);
      check("t6_stale_err", 32'(man_err), 32'd0);
    end
    xfer(1'b0, 32'h0, 2, 32'h0, 1'b0, 1'b0, 0); idle(1);
    check("t6_after", last_rdt, 32'h10203040);

    // randomized traffic with random subordinate backpressure and errors
    rnd_rdy = 1'b1;
    repeat (200) begin
      xfer(1'($urandom_range(0, 1)), 32'($urandom_range(0, 27)), int'($urandom_range(0, 2)), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
